// File: rtl/moment_sweep.sv
// Sweeps every lattice node, reads its packed D2Q9 populations and
// writes density and momentum back to the moment RAMs at the same address.
module moment_sweep #(
   parameter int GRID_DIM      = 16*16,
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
   parameter int DATA_WIDTH_F  = 9*DATA_WIDTH
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Start,
   output logic                     Busy,
   output logic                     Done,
   output logic [ADDRESS_WIDTH-1:0] rd_address,
   input  logic [DATA_WIDTH_F-1:0]  fin_data,
   output logic [ADDRESS_WIDTH-1:0] wr_address,
   output logic                     WE_p_mem,
   output logic                     WE_ux_mem,
   output logic                     WE_uy_mem,
   output logic [DATA_WIDTH-1:0]    p_data,
   output logic [DATA_WIDTH-1:0]    jx_data,
   output logic [DATA_WIDTH-1:0]    jy_data
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(GRID_DIM-1);
   localparam logic [ADDRESS_WIDTH-1:0] ONE  = ADDRESS_WIDTH'(1);

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
   logic                     cnt_q, cnt_d;
   logic                     v1_q, v1_d;
   logic [ADDRESS_WIDTH-1:0] a1_q, a1_d;
   logic                     we_q, we_d;
   logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;
   logic [DATA_WIDTH-1:0]    p_q, p_d;
   logic [DATA_WIDTH-1:0]    jx_q, jx_d;
   logic [DATA_WIDTH-1:0]    jy_q, jy_d;

   logic [DATA_WIDTH-1:0]    f [9];
   logic [DATA_WIDTH-1:0]    s_p, s_jx, s_jy;

   always_comb begin
      for (int i = 0; i < 9; i++) begin
         f[i] = fin_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Velocity weights are only 0/+1/-1, so moments reduce to add/subtract.
   always_comb begin
      s_p  = f[0] + f[1] + f[2] + f[3] + f[4]
           + f[5] + f[6] + f[7] + f[8];
      s_jx = f[1] - f[3] + f[5] - f[6] - f[7] + f[8];
      s_jy = f[2] - f[4] + f[5] + f[6] - f[7] - f[8];
   end

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      v1_d    = (state_q == READ);
      a1_d    = rd_q;
      we_d    = v1_q;
      wa_d    = v1_q ? a1_q : wa_q;
      p_d     = v1_q ? s_p  : p_q;
      jx_d    = v1_q ? s_jx : jx_q;
      jy_d    = v1_q ? s_jy : jy_q;
      unique case (state_q)
         IDLE: begin
            rd_d = '0;
            if (Start) state_d = READ;
         end
         READ: begin
            if (rd_q == LAST) begin
               state_d = DRAIN;
               cnt_d   = 1'b0;
            end else begin
               rd_d = rd_q + ONE;
            end
         end
         DRAIN: begin
            cnt_d = 1'b1;
            if (cnt_q) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            rd_d    = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         rd_q    <= '0;
         cnt_q   <= 1'b0;
         v1_q    <= 1'b0;
         a1_q    <= '0;
         we_q    <= 1'b0;
         wa_q    <= '0;
         p_q     <= '0;
         jx_q    <= '0;
         jy_q    <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         v1_q    <= v1_d;
         a1_q    <= a1_d;
         we_q    <= we_d;
         wa_q    <= wa_d;
         p_q     <= p_d;
         jx_q    <= jx_d;
         jy_q    <= jy_d;
      end
   end

   assign Busy       = (state_q == READ) || (state_q == DRAIN);
   assign Done       = (state_q == DONE);
   assign rd_address = rd_q;
   assign wr_address = wa_q;
   assign WE_p_mem   = we_q;
   assign WE_ux_mem  = we_q;
   assign WE_uy_mem  = we_q;
   assign p_data     = p_q;
   assign jx_data    = jx_q;
   assign jy_data    = jy_q;

endmodule

// File: tb/tb_moment_sweep.sv
// Self-checking bench for moment_sweep: RAM model, sweep-level
// reference model checked every cycle, plus literal moment checks.
module tb_moment_sweep;

   localparam int N  = 256;
   localparam int DW = 32;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Start;
   logic          Busy, Done;
   logic [7:0]    rd_address, wr_address;
   logic [9*DW-1:0] fin_data = '0;
   logic          WE_p_mem, WE_ux_mem, WE_uy_mem;
   logic [DW-1:0] p_data, jx_data, jy_data;

   moment_sweep dut (
      .Clk(Clk), .Reset(Reset), .Start(Start),
      .Busy(Busy), .Done(Done),
      .rd_address(rd_address), .fin_data(fin_data),
      .wr_address(wr_address),
      .WE_p_mem(WE_p_mem), .WE_ux_mem(WE_ux_mem),
      .WE_uy_mem(WE_uy_mem),
      .p_data(p_data), .jx_data(jx_data), .jy_data(jy_data)
   );

   always #5 Clk = ~Clk;

   logic [DW-1:0] mem [N][9];
   logic [DW-1:0] cap_p [N], cap_jx [N], cap_jy [N];
   int errors = 0;
   int checks = 0;
   int wcount = 0;
   int dcount = 0;

   function automatic logic [9*DW-1:0] pack(input logic [7:0] a);
      logic [9*DW-1:0] w;
      for (int i = 0; i < 9; i++) w[i*DW +: DW] = mem[a][i];
      return w;
   endfunction

   always @(posedge Clk) fin_data <= pack(rd_address);

   task automatic model(input int a, output logic [DW-1:0] p,
                        output logic [DW-1:0] jx, output logic [DW-1:0] jy);
      int cx [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
      int cy [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
      int sp, sx, sy;
      sp = 0; sx = 0; sy = 0;
      for (int i = 0; i < 9; i++) begin
         sp += int'(mem[a][i]);
         sx += cx[i] * int'(mem[a][i]);
         sy += cy[i] * int'(mem[a][i]);
      end
      p = sp; jx = sx; jy = sy;
   endtask

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Sweep-level reference: n counts edges since the Start edge E0.
   bit            m_idle = 1'b1;
   int            m_n = 0;
   logic [DW-1:0] lp = '0, ljx = '0, ljy = '0;

   always begin
      bit exp_we;
      @(posedge Clk);
      if (!Reset) begin
         m_idle = 1'b1;
         lp = '0; ljx = '0; ljy = '0;
      end else if (!m_idle) begin
         m_n++;
         if (m_n == N + 3) m_idle = 1'b1;
      end else if (Start) begin
         m_idle = 1'b0;
         m_n = 0;
      end
      #1;
      exp_we = !m_idle && m_n >= 2 && m_n <= N + 1;
      if (exp_we) model(m_n - 2, lp, ljx, ljy);
      chk("busy", 32'(Busy), 32'(!m_idle && m_n <= N + 1));
      chk("done", 32'(Done), 32'(!m_idle && m_n == N + 2));
      chk("we_p", 32'(WE_p_mem), 32'(exp_we));
      chk("we_ux", 32'(WE_ux_mem), 32'(exp_we));
      chk("we_uy", 32'(WE_uy_mem), 32'(exp_we));
      chk("p_data", p_data, lp);
      chk("jx_data", jx_data, ljx);
      chk("jy_data", jy_data, ljy);
      if (exp_we) chk("wr_address", 32'(wr_address), 32'(m_n - 2));
      if (m_idle) chk("rd_idle", 32'(rd_address), 32'd0);
      else if (m_n < N) chk("rd_address", 32'(rd_address), 32'(m_n));
      if (WE_p_mem) begin
         wcount++;
         cap_p[wr_address]  = p_data;
         cap_jx[wr_address] = jx_data;
         cap_jy[wr_address] = jy_data;
      end
      if (Done) dcount++;
   end

   task automatic fill(input int kind);
      for (int a = 0; a < N; a++)
         for (int i = 0; i < 9; i++)
            case (kind)
               0: mem[a][i] = '0;
               1: mem[a][i] = 32'd1;
               2: mem[a][i] = 32'h7FFF_FFFF;
               default: mem[a][i] = $urandom;
            endcase
   endtask

   task automatic do_sweep(input bit repulse, output int e);
      int  edges;
      bit  found;
      edges = -1; found = 1'b0; e = -1;
      wcount = 0; dcount = 0;
      @(negedge Clk);
      Start = 1'b1;
      repeat (400) begin
         @(posedge Clk);
         #1;
         edges++;
         if (Done && !found) begin
            found = 1'b1;
            e = edges;
         end
         @(negedge Clk);
         Start = repulse && (edges == 99 || edges == N + 2);
         if (found && edges >= e + 2) break;
      end
      Start = 1'b0;
      if (!found) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic sweep_ok(input string nm, input int e);
      chk({nm, "_latency"}, 32'(e), 32'(N + 2));
      chk({nm, "_writes"}, 32'(wcount), 32'(N));
      chk({nm, "_dones"}, 32'(dcount), 32'd1);
   endtask

   initial begin
      int e, dn;
      logic [DW-1:0] mp, mx, my;
      Reset = 1'b0;
      Start = 1'b0;
      fill(0);
      repeat (3) @(negedge Clk);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_we", 32'(WE_p_mem | WE_ux_mem | WE_uy_mem), 32'd0);
      chk("rst_rd", 32'(rd_address), 32'd0);
      chk("rst_wr", 32'(wr_address), 32'd0);
      chk("rst_data", p_data | jx_data | jy_data, 32'd0);
      Reset = 1'b1;
      repeat (2) @(negedge Clk);

      mem[3][1] = 32'd5;
      mem[4][7] = 32'd2;
      model(3, mp, mx, my);
      chk("model3_p", mp, 32'd5);
      chk("model3_jx", mx, 32'd5);
      chk("model3_jy", my, 32'd0);
      model(4, mp, mx, my);
      chk("model4_jx", mx, 32'hFFFF_FFFE);
      do_sweep(1'b0, e);
      sweep_ok("moments", e);
      chk("n3_p", cap_p[3], 32'd5);
      chk("n3_jx", cap_jx[3], 32'd5);
      chk("n3_jy", cap_jy[3], 32'd0);
      chk("n4_p", cap_p[4], 32'd2);
      chk("n4_jx", cap_jx[4], 32'hFFFF_FFFE);
      chk("n4_jy", cap_jy[4], 32'hFFFF_FFFE);

      fill(1);
      do_sweep(1'b0, e);
      sweep_ok("rest", e);
      for (int a = 0; a < N; a++) begin
         chk("rest_p", cap_p[a], 32'd9);
         chk("rest_jx", cap_jx[a], 32'd0);
         chk("rest_jy", cap_jy[a], 32'd0);
      end

      fill(2);
      model(0, mp, mx, my);
      chk("model_ovf_p", mp, 32'h7FFF_FFF7);
      do_sweep(1'b0, e);
      sweep_ok("ovf", e);
      chk("ovf_p0", cap_p[0], 32'h7FFF_FFF7);
      chk("ovf_p255", cap_p[255], 32'h7FFF_FFF7);
      chk("ovf_jx", cap_jx[128], 32'd0);
      chk("ovf_jy", cap_jy[128], 32'd0);

      fill(3);
      do_sweep(1'b1, e);
      sweep_ok("repulse", e);

      fill(3);
      wcount = 0; dcount = 0; dn = 0;
      @(negedge Clk);
      Start = 1'b1;
      repeat (800) begin
         @(posedge Clk);
         #1;
         if (Done) dn++;
         if (dn == 2) break;
      end
      @(negedge Clk);
      Start = 1'b0;
      repeat (5) @(negedge Clk);
      chk("held_dones", 32'(dcount), 32'd2);
      chk("held_writes", 32'(wcount), 32'(2 * N));

      fill(3);
      @(negedge Clk);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (50) @(posedge Clk);
      #3 Reset = 1'b0;
      #1;
      chk("abort_busy", 32'(Busy), 32'd0);
      chk("abort_done", 32'(Done), 32'd0);
      chk("abort_we", 32'(WE_p_mem | WE_ux_mem | WE_uy_mem), 32'd0);
      chk("abort_addr", 32'(rd_address | wr_address), 32'd0);
      chk("abort_data", p_data | jx_data | jy_data, 32'd0);
      wcount = 0; dcount = 0;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      chk("abort_nowrite", 32'(wcount + dcount), 32'd0);
      do_sweep(1'b0, e);
      sweep_ok("post_reset", e);

      repeat (3) @(negedge Clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
